// File: rtl/mixer_gain_ramp.sv
// Walks the mixer coefficient table once per tick, stepping each shadowed coefficient
// toward its target and writing the new value out over a pipelined Wishbone master.
module mixer_gain_ramp #(
    parameter int CFGAW     = 32,
    parameter int CFGDW     = 32,
    parameter int COEFW     = 18,
    parameter int NCOEF     = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [COEFW-1:0]    s_tdata,
    input  logic [$clog2(NCOEF)-1:0]   s_tid,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [COEFW-2:0]           step,
    input  logic                       tick,
    output logic                       cyc_o,
    output logic                       stb_o,
    output logic                       we_o,
    output logic [CFGAW-1:0]           addr_o,
    output logic [CFGDW-1:0]           data_o,
    input  logic                       stall_i,
    input  logic                       ack_i,
    output logic                       busy,
    output logic                       done
);

    localparam int IDW = $clog2(NCOEF);
    localparam logic [IDW:0]   ID_LIM = (IDW+1)'(NCOEF);
    localparam logic [IDW-1:0] LAST   = IDW'(NCOEF - 1);

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, WAIT_ACK} state_t;

    state_t                  state;
    logic [IDW-1:0]          idx;
    logic                    pending;
    logic signed [COEFW-1:0] target  [NCOEF];
    logic signed [COEFW-1:0] current [NCOEF];
    logic signed [COEFW-1:0] nxt_val;
    logic signed [COEFW-1:0] scan_next;

    // One ramp step from cur toward tgt; the extra bit keeps target-current exact.
    function automatic logic signed [COEFW-1:0] ramp_next(
        input logic signed [COEFW-1:0] tgt,
        input logic signed [COEFW-1:0] cur,
        input logic [COEFW-2:0]        stp
    );
        logic signed [COEFW:0] diff;
        logic [COEFW:0]        mag;
        logic [COEFW:0]        stp_x;
        logic signed [COEFW:0] moved;
        diff  = {tgt[COEFW-1], tgt} - {cur[COEFW-1], cur};
        mag   = diff[COEFW] ? (~diff + 1'b1) : diff;
        stp_x = {2'b00, stp};
        if (stp == '0 || mag <= stp_x) begin
            return tgt;
        end
        moved = diff[COEFW] ? ({cur[COEFW-1], cur} - $signed(stp_x))
                            : ({cur[COEFW-1], cur} + $signed(stp_x));
        return moved[COEFW-1:0];
    endfunction

    assign scan_next = ramp_next(target[idx], current[idx], step);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            pending  <= 1'b0;
            cyc_o    <= 1'b0;
            stb_o    <= 1'b0;
            we_o     <= 1'b0;
            addr_o   <= '0;
            data_o   <= '0;
            done     <= 1'b0;
            s_tready <= 1'b0;
            nxt_val  <= '0;
            for (int i = 0; i < NCOEF; i++) begin
                target[i]  <= '0;
                current[i] <= '0;
            end
        end else begin
            s_tready <= 1'b1;
            done     <= 1'b0;
            if (s_tvalid && s_tready && ({1'b0, s_tid} < ID_LIM)) begin
                target[s_tid] <= s_tdata;
            end
            // Ticks arriving mid-pass collapse into a single follow-up pass.
            if (tick && state != IDLE) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick || pending) begin
                        state   <= SCAN;
                        idx     <= '0;
                        pending <= 1'b0;
                    end
                end
                SCAN: begin
                    if (target[idx] == current[idx]) begin
                        if (idx == LAST) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        nxt_val <= scan_next;
                        addr_o  <= CFGAW'(BASE_ADDR) + CFGAW'(idx);
                        data_o  <= {{(CFGDW-COEFW){scan_next[COEFW-1]}}, scan_next};
                        cyc_o   <= 1'b1;
                        stb_o   <= 1'b1;
                        we_o    <= 1'b1;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (!stall_i) begin
                        stb_o <= 1'b0;
                        we_o  <= 1'b0;
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_i) begin
                        cyc_o        <= 1'b0;
                        current[idx] <= nxt_val;
                        if (idx == LAST) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mixer_gain_ramp.sv
// Bench for mixer_gain_ramp: a Wishbone slave responder records writes, and a
// pass-level model of the ramp rules predicts them.
module tb_mixer_gain_ramp;

    localparam int NC   = 4;
    localparam int CW   = 18;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int BASE = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic signed [CW-1:0] s_tdata = '0;
    logic [1:0]           s_tid = '0;
    logic                 s_tvalid = 1'b0;
    logic                 s_tready;
    logic [CW-2:0]        step = '0;
    logic                 tick = 1'b0;
    logic                 cyc_o, stb_o, we_o;
    logic [AW-1:0]        addr_o;
    logic [DW-1:0]        data_o;
    logic                 stall_i, ack_i;
    logic                 busy, done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int stall_cfg = 0;
    int ack_dly = 0;
    int st_cnt = 0;
    int ak_cnt = 0;
    int m_tgt[NC];
    int m_cur[NC];
    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];

    mixer_gain_ramp #(.CFGAW(AW), .CFGDW(DW), .COEFW(CW), .NCOEF(NC), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tid(s_tid), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .step(step), .tick(tick), .cyc_o(cyc_o), .stb_o(stb_o),
        .we_o(we_o), .addr_o(addr_o), .data_o(data_o), .stall_i(stall_i), .ack_i(ack_i),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    // Slave: stalls stall_cfg cycles per request, acks ack_dly cycles after acceptance.
    initial begin
        stall_i = 1'b0;
        ack_i   = 1'b0;
        forever begin
            @(negedge clk);
            stall_i = 1'b0;
            ack_i   = 1'b0;
            if (cyc_o === 1'b1 && stb_o === 1'b1) begin
                if (st_cnt < stall_cfg) begin
                    stall_i = 1'b1;
                    st_cnt++;
                end else begin
                    wr_q.push_back({addr_o, data_o});
                    st_cnt = 0;
                    ak_cnt = 0;
                end
            end else if (cyc_o === 1'b1) begin
                if (ak_cnt >= ack_dly) ack_i = 1'b1;
                else ak_cnt++;
            end else begin
                st_cnt = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ramp(input int cur, input int tgt, input int stp);
        int d = tgt - cur;
        int mag = (d < 0) ? -d : d;
        if (stp == 0 || mag <= stp) return tgt;
        return (d > 0) ? cur + stp : cur - stp;
    endfunction

    task automatic model_pass(input int stp);
        for (int i = 0; i < NC; i++) begin
            if (m_cur[i] != m_tgt[i]) begin
                m_cur[i] = ramp(m_cur[i], m_tgt[i], stp);
                exp_q.push_back({32'(BASE + i), 32'(m_cur[i])});
            end
        end
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
            check({tag, "_wr"}, wr_q[k], exp_q[k]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick = 1'b0; s_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cyc", cyc_o, 0);
        check("rst_stb", stb_o, 0);
        check("rst_we", we_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_data", data_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tready", s_tready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("tready_after_rst", s_tready, 1);
        for (int i = 0; i < NC; i++) begin m_cur[i] = 0; m_tgt[i] = 0; end
    endtask

    task automatic set_target(input int id, input int val);
        s_tid = 2'(id); s_tdata = CW'(val); s_tvalid = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
        m_tgt[id] = val;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic run_pass(input string tag, input int stp);
        step = (CW-1)'(stp);
        exp_q.delete();
        model_pass(stp);
        wr_q.delete();
        pulse_tick();
        wait_done(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        compare_writes(tag);
    endtask

    initial begin
        int bc, lim, d0, sc, cc, v;
        logic [31:0] ramp_exp[4];
        do_reset();

        // All targets zero: four SCAN cycles, no bus cycle, one done pulse.
        d0 = done_cnt; wr_q.delete();
        pulse_tick();
        bc = 0; lim = 0;
        while (done !== 1'b1 && lim < 50) begin
            if (busy === 1'b1) bc++;
            lim++;
            @(negedge clk);
        end
        check("idle_pass_busy_cycles", bc, 4);
        check("idle_pass_done", done, 1);
        @(negedge clk);
        check("idle_pass_busy_after", busy, 0);
        check("idle_pass_done_count", done_cnt - d0, 1);
        check("idle_pass_no_write", wr_q.size(), 0);

        // Ramp 0 -> 1000 in steps of 300.
        ramp_exp[0] = 300; ramp_exp[1] = 600; ramp_exp[2] = 900; ramp_exp[3] = 1000;
        stall_cfg = 0; ack_dly = 0;
        set_target(2, 1000);
        for (int p = 0; p < 5; p++) begin
            run_pass("ramp", 300);
            if (p < 4) begin
                check("ramp_const_n", wr_q.size(), 1);
                if (wr_q.size() > 0) check("ramp_const_wr", wr_q[0], {32'h12, ramp_exp[p]});
            end else begin
                check("ramp_fifth_nowr", wr_q.size(), 0);
            end
        end

        // Negative jump with step 0.
        set_target(0, -5);
        run_pass("neg_jump", 0);
        check("neg_jump_const", (wr_q.size() > 0) ? wr_q[0] : 64'h0, {32'h10, 32'hFFFF_FFFB});
        run_pass("neg_settled", 0);

        // Stalled request: stb held four cycles with stable address/data.
        stall_cfg = 3; ack_dly = 2;
        set_target(1, 1234);
        step = '0; exp_q.delete(); model_pass(0); wr_q.delete();
        pulse_tick();
        lim = 0;
        while (stb_o !== 1'b1 && lim < 50) begin @(negedge clk); lim++; end
        sc = 0;
        while (stb_o === 1'b1 && sc < 20) begin
            check("stall_addr", addr_o, 32'h11);
            check("stall_data", data_o, 32'd1234);
            sc++;
            @(negedge clk);
        end
        check("stall_stb_len", sc, 4);
        cc = 0;
        while (cyc_o === 1'b1 && cc < 20) begin cc++; @(negedge clk); end
        check("stall_cyc_tail", cc, 3);
        wait_done("stall");
        @(negedge clk);
        compare_writes("stall");

        // Three ticks during a pass coalesce into exactly one follow-up pass.
        do_reset();
        stall_cfg = 3; ack_dly = 3;
        set_target(1, 5000);
        step = (CW-1)'(1000);
        exp_q.delete(); model_pass(1000); model_pass(1000);
        wr_q.delete(); d0 = done_cnt;
        pulse_tick();
        repeat (3) begin pulse_tick(); @(negedge clk); end
        wait_done("coal_first");
        @(negedge clk);
        check("coal_restart_busy", busy, 1);
        check("coal_restart_done", done, 0);
        wait_done("coal_second");
        repeat (20) @(negedge clk);
        check("coal_done_count", done_cnt - d0, 2);
        check("coal_idle", busy, 0);
        compare_writes("coal");

        // Reset during WAIT_ACK abandons the transaction and clears shadows and pending.
        do_reset();
        stall_cfg = 0; ack_dly = 0;
        set_target(3, 600);
        run_pass("pre_rst", 0);
        set_target(3, 900);
        ack_dly = 50;
        pulse_tick();
        lim = 0;
        while (!(cyc_o === 1'b1 && stb_o === 1'b0) && lim < 50) begin @(negedge clk); lim++; end
        check("rst_mid_in_wait", {cyc_o, stb_o}, 2'b10);
        pulse_tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_cyc", cyc_o, 0);
        do_reset();
        ack_dly = 0;
        bc = 0;
        repeat (10) begin if (busy === 1'b1) bc++; @(negedge clk); end
        check("rst_mid_no_pending", bc, 0);
        set_target(3, 900);
        run_pass("post_rst", 300);
        check("post_rst_const", (wr_q.size() > 0) ? wr_q[0] : 64'h0, {32'h13, 32'd300});

        // Randomized targets, steps and bus timing.
        for (int it = 0; it < 16; it++) begin
            stall_cfg = $urandom_range(0, 2);
            ack_dly   = $urandom_range(0, 2);
            for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
                if (it % 4 == 3) v = int'($urandom_range(0, 262142)) - 131071;
                else v = int'($urandom_range(0, 4000)) - 2000;
                set_target(int'($urandom_range(0, NC - 1)), v);
            end
            if ($urandom_range(0, 3) == 0) run_pass("rand", 0);
            else if (it % 4 == 3) run_pass("rand", int'($urandom_range(1, 131071)));
            else run_pass("rand", int'($urandom_range(1, 1500)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
